// File: rtl/cla_seq_divider_pkg.sv
// cla_seq_divider_pkg: state encoding, default width and counter sizing for the sequential divider.
package cla_seq_divider_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int DEF_WIDTH = 16;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/cla_seq_divider_cla_subtractor.sv
// cla_subtractor: a - b as a + ~b + 1 through 4-bit lookahead groups and a second-level lookahead unit.
module cla_subtractor #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] difference,
    output logic         carryOutput
);
    localparam int NG = (W + 3) / 4;
    localparam int NP = 4 * NG;
    logic [NP-1:0] ap, bp, g, p;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic [W-1:0]  c;
    // inverted zero padding gives propagate-only bits, so the top carry equals bit W's carry
    assign ap = NP'(a);
    assign bp = ~NP'(b);
    assign g = ap & bp;
    assign p = ap ^ bp;
    always_comb begin
        logic pr, acc;
        gg = '0;
        gp = '0;
        gc = '0;
        c = '0;
        pr = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < NG; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (&p[4*k+2 +: 2] & g[4*k+1]) | (&p[4*k+1 +: 3] & g[4*k]);
        end
        for (int k = 0; k <= NG; k++) begin
            pr = 1'b1;
            acc = 1'b0;
            for (int j = k - 1; j >= 0; j--) begin
                acc = acc | (pr & gg[j]);
                pr = pr & gp[j];
            end
            gc[k] = acc | pr;
        end
        for (int k = 0; k < NG; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (4 * k + i < W) begin
                    pr = 1'b1;
                    acc = 1'b0;
                    for (int j = i - 1; j >= 0; j--) begin
                        acc = acc | (pr & g[4*k+j]);
                        pr = pr & p[4*k+j];
                    end
                    c[4*k+i] = acc | (pr & gc[k]);
                end
            end
        end
    end
    assign difference = p[W-1:0] ^ c;
    assign carryOutput = gc[NG];
endmodule

// File: rtl/cla_seq_divider.sv
// cla_seq_divider: restoring unsigned divider, one quotient bit per clock via a CLA subtractor.
// Optional DIV_EARLY_EXIT_EN: finishes in one cycle when dividend < divisor.
module cla_seq_divider
    import cla_seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);
    localparam int CW = cnt_w(WIDTH);
    logic [1:0]       state;
    logic [WIDTH-1:0] r, q, d, r_next, q_next;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   s, sub_a, sub_b, diff;
    logic             co, accept;
    assign s = {r, q[WIDTH-1]};
`ifdef DIV_EARLY_EXIT_EN
    // outside RUN the subtractor is free, so it compares the incoming operands
    assign sub_a = state == RUN ? s : {1'b0, dividend};
    assign sub_b = {1'b0, state == RUN ? d : divisor};
`else
    assign sub_a = s;
    assign sub_b = {1'b0, d};
`endif
    cla_subtractor #(.W(WIDTH + 1)) u_sub (
        .a(sub_a),
        .b(sub_b),
        .difference(diff),
        .carryOutput(co)
    );
    // a restored remainder is always below the divisor, so WIDTH bits suffice
    assign r_next = co ? diff[WIDTH-1:0] : s[WIDTH-1:0];
    assign q_next = {q[WIDTH-2:0], co};
    assign accept = start && state != RUN;
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            r <= '0;
            q <= '0;
            d <= '0;
            count <= '0;
            quotient <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else if (accept) begin
            d <= divisor;
            q <= dividend;
            r <= '0;
            count <= '0;
            if (divisor == '0) begin
                state <= DONE;
                quotient <= '1;
                remainder <= dividend;
                divByZero <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
            end else if (!co) begin
                state <= DONE;
                quotient <= '0;
                remainder <= dividend;
                divByZero <= 1'b0;
`endif
            end else begin
                state <= RUN;
            end
        end else if (state == RUN) begin
            r <= r_next;
            q <= q_next;
            count <= count + 1'b1;
            if (count == CW'(WIDTH - 1)) begin
                state <= DONE;
                quotient <= q_next;
                remainder <= r_next;
                divByZero <= 1'b0;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_cla_seq_divider.sv
// tb_cla_seq_divider: directed vectors against an arithmetic reference model of the divider.
module tb_cla_seq_divider;
    localparam int WIDTH = 16;
`ifdef DIV_EARLY_EXIT_EN
    localparam int LT_LAT = 0;
`else
    localparam int LT_LAT = 16;
`endif
    logic clk = 1'b0;
    logic rstN, start;
    logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
    logic busy, done, divByZero;
    int n_cmp = 0, n_bad = 0;

    cla_seq_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rstN(rstN), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .divByZero(divByZero)
    );

    always #5 clk = ~clk;

    // reference model: plain division, timed by a countdown of remaining busy cycles
    int m_run;
    logic e_done, e_dz;
    logic [WIDTH-1:0] e_q, e_r, p_q, p_r;
    wire e_busy = m_run > 0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_run <= 0;
            e_done <= 1'b0;
            e_q <= '0;
            e_r <= '0;
            e_dz <= 1'b0;
            p_q <= '0;
            p_r <= '0;
        end else begin
            e_done <= 1'b0;
            if (m_run > 0) begin
                m_run <= m_run - 1;
                if (m_run == 1) begin
                    e_done <= 1'b1;
                    e_q <= p_q;
                    e_r <= p_r;
                    e_dz <= 1'b0;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    e_done <= 1'b1;
                    e_q <= '1;
                    e_r <= dividend;
                    e_dz <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
                end else if (dividend < divisor) begin
                    e_done <= 1'b1;
                    e_q <= '0;
                    e_r <= dividend;
                    e_dz <= 1'b0;
`endif
                end else begin
                    m_run <= WIDTH;
                    p_q <= dividend / divisor;
                    p_r <= dividend % divisor;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("not_both", 32'(busy & done), 32'(0));
        check("quotient", 32'(quotient), 32'(e_q));
        check("remainder", 32'(remainder), 32'(e_r));
        check("divByZero", 32'(divByZero), 32'(e_dz));
    end

    task automatic fire(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [WIDTH-1:0] xq, input logic [WIDTH-1:0] xr,
                             input logic xdz, input int xlat);
        int lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(xlat));
        check("lit_quotient", 32'(quotient), 32'(xq));
        check("lit_remainder", 32'(remainder), 32'(xr));
        check("lit_divByZero", 32'(divByZero), 32'(xdz));
        check("model_quotient", 32'(e_q), 32'(xq));
        check("model_remainder", 32'(e_r), 32'(xr));
    endtask

    task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] xq, input logic [WIDTH-1:0] xr,
                       input logic xdz, input int xlat);
        @(negedge clk);
        fire(a, b);
        wait_done(xq, xr, xdz, xlat);
    endtask

    initial begin
        rstN = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rstN = 1'b1;
        run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        run(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
        run(16'h1234, 16'hFFFF, 16'd0, 16'h1234, 1'b0, LT_LAT);
        run(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);
        run(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
        fire(16'd50, 16'd5);
        wait_done(16'd10, 16'd0, 1'b0, 16);
        run(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 16);
        // abort: ignored second start, then reset mid-run
        @(negedge clk);
        fire(16'd1000, 16'd3);
        repeat (4) @(negedge clk);
        fire(16'd9, 16'd2);
        check("ignored_start_busy", 32'(busy), 32'(1));
        repeat (4) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        check("abort_quotient", 32'(quotient), 32'(0));
        check("abort_remainder", 32'(remainder), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_divByZero", 32'(divByZero), 32'(0));
        rstN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'(0));
        end
        run(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 16);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
